// File: rtl/parking_pkg.sv
// Shared types, segment encodings and digit-split helper for the parking-lot display.
package parking_pkg;

   localparam int unsigned MAX_CARS = 15;

   typedef logic [6:0] seg_t;        // {g,f,e,d,c,b,a}, active-low
   typedef logic [1:0] digit_idx_t;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] units;
   } bcd_t;

   localparam seg_t SEG_0     = 7'b1000000;
   localparam seg_t SEG_1     = 7'b1111001;
   localparam seg_t SEG_2     = 7'b0100100;
   localparam seg_t SEG_3     = 7'b0110000;
   localparam seg_t SEG_4     = 7'b0011001;
   localparam seg_t SEG_5     = 7'b0010010;
   localparam seg_t SEG_6     = 7'b0000010;
   localparam seg_t SEG_7     = 7'b1111000;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0010000;
   localparam seg_t SEG_DASH  = 7'b0111111;
   localparam seg_t SEG_BLANK = 7'b1111111;

   // Values never exceed 15, so the tens digit is at most 1.
   function automatic bcd_t split_bcd(input logic [3:0] v);
      bcd_t r;
      if (v >= 4'd10) begin
         r.tens  = 4'd1;
         r.units = v - 4'd10;
      end else begin
         r.tens  = 4'd0;
         r.units = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/occupancy_display_if.sv
// Occupancy input from the counting block and the display/status outputs.
interface occupancy_display_if;
   logic [3:0]          no_cars;
   logic [3:0]          an;
   parking_pkg::seg_t   seg;
   logic                dp;
   logic                lot_full;
   logic                lot_empty;

   modport master (output no_cars, input  an, seg, dp, lot_full, lot_empty);
   modport slave  (input  no_cars, output an, seg, dp, lot_full, lot_empty);
endinterface

// File: rtl/seg7_decoder.sv
// Digit-to-segment decoder; blank flag or non-decimal digit turns all segments off.
module seg7_decoder
   import parking_pkg::*;
(
   input  logic [3:0] i_digit,
   input  logic       i_blank,
   output seg_t       o_seg_c
);

   always_comb begin
      o_seg_c = SEG_BLANK;
      if (!i_blank) begin
         case (i_digit)
            4'd0:    o_seg_c = SEG_0;
            4'd1:    o_seg_c = SEG_1;
            4'd2:    o_seg_c = SEG_2;
            4'd3:    o_seg_c = SEG_3;
            4'd4:    o_seg_c = SEG_4;
            4'd5:    o_seg_c = SEG_5;
            4'd6:    o_seg_c = SEG_6;
            4'd7:    o_seg_c = SEG_7;
            4'd8:    o_seg_c = SEG_8;
            4'd9:    o_seg_c = SEG_9;
            default: o_seg_c = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/occupancy_display.sv
// Four-digit multiplexed occupancy/free-space display with full/empty status flags.
module occupancy_display
   import parking_pkg::*;
#(
   parameter int unsigned CAPACITY    = 12,
   parameter int unsigned REFRESH_DIV = 50_000,
   parameter int unsigned BLINK_DIV   = 25_000_000
)(
   input  logic               clk,
   input  logic               reset,
   occupancy_display_if.slave bus
);

   localparam int unsigned REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned BLINK_W = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;
   localparam logic [3:0]  CAP4    = 4'(CAPACITY);

   logic [3:0]         r_count;
   logic               r_lot_full;
   logic               r_lot_empty;
   logic [REF_W-1:0]   r_ref_cnt;
   digit_idx_t         r_digit_idx;
   logic [BLINK_W-1:0] r_blink_cnt;
   logic               r_blink_phase;
   logic [3:0]         r_an;
   seg_t               r_seg;
   logic               r_dp;

   logic               w_full;
   logic [3:0]         w_free;
   bcd_t               w_occ;
   bcd_t               w_free_bcd;
   logic [3:0]         w_digit;
   logic               w_blank;
   logic               w_dash;
   seg_t               w_dec_seg;

   assign w_full     = (r_count == CAP4);
   assign w_free     = CAP4 - r_count;
   assign w_occ      = split_bcd(r_count);
   assign w_free_bcd = split_bcd(w_free);

   // Input register with silent clamp, plus status flags one cycle behind it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count     <= 4'd0;
         r_lot_full  <= 1'b0;
         r_lot_empty <= 1'b1;
      end else begin
         r_count     <= (bus.no_cars > CAP4) ? CAP4 : bus.no_cars;
         r_lot_full  <= w_full;
         r_lot_empty <= (r_count == 4'd0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ref_cnt   <= '0;
         r_digit_idx <= 2'd0;
      end else if (r_ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
         r_ref_cnt   <= '0;
         r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
         r_ref_cnt   <= r_ref_cnt + REF_W'(1);
      end
   end

   // Parked at the visible phase while not full so each full episode starts with dashes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (!w_full) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
      end
   end

   always_comb begin
      w_digit = 4'd0;
      w_blank = 1'b0;
      w_dash  = 1'b0;
      case (r_digit_idx)
         2'd0: w_digit = w_occ.units;
         2'd1: begin
            w_digit = w_occ.tens;
            w_blank = (w_occ.tens == 4'd0);
         end
         2'd2: begin
            w_digit = w_free_bcd.units;
            w_dash  = w_full;
         end
         default: begin
            w_digit = w_free_bcd.tens;
            w_blank = (w_free_bcd.tens == 4'd0);
            w_dash  = w_full;
         end
      endcase
   end

   seg7_decoder u_dec (
      .i_digit (w_digit),
      .i_blank (w_blank),
      .o_seg_c (w_dec_seg)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_an  <= 4'b1111;
         r_seg <= SEG_BLANK;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= ~(4'b0001 << r_digit_idx);
         r_seg <= w_dash ? (r_blink_phase ? SEG_DASH : SEG_BLANK) : w_dec_seg;
         r_dp  <= (r_digit_idx != 2'd2);
      end
   end

   assign bus.an        = r_an;
   assign bus.seg       = r_seg;
   assign bus.dp        = r_dp;
   assign bus.lot_full  = r_lot_full;
   assign bus.lot_empty = r_lot_empty;

endmodule

// File: doc/occupancy_display.md
# occupancy_display

Downstream display stage for the parking-lot counter. It consumes the 4-bit occupancy count `no_cars` produced by the entry/exit counting block. It drives a 4-digit, time-multiplexed, common-anode seven-segment display: occupied count on the right pair, free spaces on the left pair. It also raises registered `lot_full` and `lot_empty` status flags.

## Interface
- `CAPACITY`, 12: lot size, 1..15.
- `REFRESH_DIV`, 50_000: clock cycles each digit is held during the scan; ≥ 2.
- `BLINK_DIV`, 25_000_000: clock cycles per blink half-period when full; ≥ 2.
- `clk` input 1: single system clock.
- `reset` input 1: asynchronous, active-high reset.
- `no_cars` input 4: current occupancy from the counting block, binary.
- `an` output 4: digit enables, active-low; bit 0 is the rightmost digit.
- `seg` output 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` output 1: decimal point, active-low.
- `lot_full` output 1: high when clamped occupancy equals `CAPACITY`.
- `lot_empty` output 1: high when occupancy is 0.

## Operation
- **Input register:** `count_q <= min(no_cars, CAPACITY)` every cycle. Over-capacity values clamp silently.
- **Derived values:** `free = CAPACITY - count_q`, never negative because of the clamp. Both values split into tens and units (0..15).
- **Flags:** `lot_full <= (count_q == CAPACITY)`, `lot_empty <= (count_q == 0)`, both registered.
- **Scan counter:** `ref_cnt` runs 0..REFRESH_DIV-1. On wrap, 2-bit `digit_idx` advances 0→1→2→3→0.
- **Digit content:**
  - Digit 0: occupied units.
  - Digit 1: occupied tens, blank when 0.
  - Digit 2: free units.
  - Digit 3: free tens, blank when 0.
  - `dp` is lit only while digit 2 is active, as a separator.
- **Full display:** while `lot_full`, digits 3 and 2 show dash (`0111111`) instead of free-space digits. They blink: dash when `blink_phase` = 1, all segments off when 0.
- **Blink timer:** `blink_cnt` runs 0..BLINK_DIV-1 only while `lot_full`. `blink_phase` toggles on wrap. When not full, `blink_cnt` = 0 and `blink_phase` = 1, so every full episode starts in the visible phase.
- **Blank:** `seg` = `1111111`, with the digit still enabled.
- **Reset values:**
  - `count_q` = 0, `ref_cnt` = 0, `digit_idx` = 0, `blink_cnt` = 0, `blink_phase` = 1.
  - `an` = `1111`, `seg` = `1111111`, `dp` = 1.
  - `lot_full` = 0, `lot_empty` = 1.
- **Reset mid-operation:** all state returns to reset values immediately. The scan restarts at digit 0 after release.

## Timing
- `no_cars` change reaches `count_q` after 1 cycle. It reaches `lot_full`/`lot_empty` after 2 cycles.
- `an`, `seg`, `dp` are registered from `digit_idx`, `count_q` and `blink_phase` of the previous cycle.
- **First cycle after reset release:** `an` = `1110`, showing digit 0 of `count_q` = 0.
- Each digit is enabled for exactly REFRESH_DIV consecutive cycles. A full scan takes 4·REFRESH_DIV cycles.
- Exactly one `an` bit is low at any time outside reset, with no overlap cycle.
- A count change appears on the digit currently being scanned within 2 cycles.
- **Simultaneous events:** a `no_cars` change on the same cycle as a digit advance shows the old value for that one registered cycle, then the new value.

## Structure
- **Package `parking_pkg`:**
  - Segment constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`, active-low `{g,f,e,d,c,b,a}`.
  - `digit_idx_t` (2-bit typedef).
  - `MAX_CARS` = 15.
- **Sub-module `seg7_decoder`:** combinational, 4-bit digit plus blank flag in, 7-bit segments out. Instantiated once, on the muxed digit.
- The top of `occupancy_display` holds the input register, scan counter, blink timer, digit mux and output registers.

## Test plan
All scenarios use `CAPACITY`=12, `REFRESH_DIV`=4, `BLINK_DIV`=8.
- **Reset, then `no_cars`=0:**
  - During reset: `an`=`1111`, `seg`=`1111111`, `lot_empty`=1, `lot_full`=0.
  - After release: digit 0 `1000000` ("0"), digit 1 blank, digit 2 `0100100` ("2") with `dp`=0, digit 3 `1111001` ("1").
- **Scan order:** `an` sequence is `1110`, `1101`, `1011`, `0111`, repeating, each held exactly 4 cycles.
- **`no_cars`=7:**
  - Digit 0 `1111000`, digit 1 blank, digit 2 `0010010` ("5"), digit 3 blank.
  - `lot_empty` falls 2 cycles after the input change.
- **`no_cars`=12:**
  - `lot_full` rises 2 cycles later.
  - Digits 3 and 2 show `0111111` for 8 cycles, then blank for 8, repeating.
  - Digit 1 `1111001`, digit 0 `0100100`.
- **`no_cars`=15:** output identical to the `no_cars`=12 case (clamp), `lot_full`=1.
- **Reset pulse mid-blink while full:**
  - Outputs go to reset values without waiting for a clock edge.
  - After release: scan restarts at `an`=`1110`, and `blink_phase` is in the visible phase.
